// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Purpose:
//   Control unit for a multi-cycle MIPS datapath. A registered Moore FSM walks
//   each instruction through fetch, decode, execute, memory and writeback
//   steps. It stalls in any memory step until the memory reports mem_ready.
//   addi and j can each be enabled or disabled with a parameter.
//
// Parameters:
//   OPCODE_W  opcode field width (IR[31:26])
//   ALUOP_W   width of the ALUOp bus sent to the ALU decoder
//   EN_ADDI   1 = opcode 001000 (addi) is legal
//   EN_JUMP   1 = opcode 000010 (j) is legal
//   STATE_W   width of the state_o debug output
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     instruction opcode, looked at only in DECODE
//   mem_ready  memory completes the current access this cycle
//   mem_req    memory access request
//   IorD       memory address select: 0 = PC, 1 = ALUOut
//   MemWrite   store strobe, valid together with mem_req
//   IRWrite    load the instruction register
//   RegDst     register file write address: 1 = rd, 0 = rt
//   MemtoReg   register file write data: 1 = MDR, 0 = ALUOut
//   RegWrite   register file write enable
//   ALUSrcA    ALU A operand: 0 = PC, 1 = regA
//   ALUSrcB    ALU B operand: 00 regB, 01 +4, 10 signext imm, 11 imm<<2
//   ALUOp      00 add, 01 sub, 10 use the funct field
//   Branch     write PC if the ALU zero flag is set
//   PCWrite    unconditional PC write
//   PCSrc      PC source: 00 ALU, 01 ALUOut, 10 jump target
//   instr_done one-cycle pulse on an instruction's final cycle
//   illegal    one-cycle pulse in DECODE for an unsupported opcode
//   state_o    current state encoding (IDLE = 0)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int EN_ADDI  = 1,
    parameter int EN_JUMP  = 1,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Branch,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                instr_done,
    output logic                illegal,
    output logic [STATE_W-1:0]  state_o
);

    // -------------------------------------------------------------------------
    // State encodings. IDLE must be zero so that state_o reads 0 in reset.
    // Encodings 13..15 are unused and recover to FETCH.
    // -------------------------------------------------------------------------
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_RTYPE_EX = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_ADDI_EX  = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    // ALUOp codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Operand B selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC sources
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // MEMADR has to choose between MEM_RD and MEM_WR after the IR may already
    // hold something else on the opcode lines, so the lw/sw choice is
    // captured in DECODE.
    logic op_sw_q;
    logic op_sw_d;

    // -------------------------------------------------------------------------
    // Opcode classification, meaningful only in DECODE
    // -------------------------------------------------------------------------
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_addi;
    logic is_jump;
    logic decode_legal;

    assign is_rtype     = (opcode == OP_RTYPE);
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_beq       = (opcode == OP_BEQ);
    assign is_addi      = (opcode == OP_ADDI) && (EN_ADDI != 0);
    assign is_jump      = (opcode == OP_J) && (EN_JUMP != 0);
    assign decode_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_jump;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_sw_q <= op_sw_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        op_sw_d = op_sw_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                op_sw_d = is_sw;
                if (is_rtype) begin
                    state_d = S_RTYPE_EX;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEMADR;
                end else if (is_beq) begin
                    state_d = S_BEQ;
                end else if (is_addi) begin
                    state_d = S_ADDI_EX;
                end else if (is_jump) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                state_d = op_sw_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                state_d = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_RTYPE_EX: begin
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                state_d = S_FETCH;
            end
            S_BEQ: begin
                state_d = S_FETCH;
            end
            S_ADDI_EX: begin
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                state_d = S_FETCH;
            end
            S_JUMP: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore). The only input-dependent terms are the handshake
    // completions in FETCH and MEM_WR and the illegal flag in DECODE.
    // -------------------------------------------------------------------------
    logic [1:0] alu_op;

    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        alu_op     = ALU_ADD;
        Branch     = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed,
                // together with the IR load, on the cycle memory delivers.
                mem_req = 1'b1;
                IorD    = 1'b0;
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_FOUR;
                alu_op  = ALU_ADD;
                PCSrc   = PC_ALU;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_IMMSH;
                alu_op  = ALU_ADD;
                illegal = ~decode_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                RegDst     = 1'b0;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REGB;
                alu_op  = ALU_FUNCT;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                MemtoReg   = 1'b0;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REGB;
                alu_op     = ALU_SUB;
                Branch     = 1'b1;
                PCSrc      = PC_ALUOUT;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALU_ADD;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b0;
                MemtoReg   = 1'b0;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = PC_JUMP;
                instr_done = 1'b1;
            end
            default: begin
                // IDLE and unused encodings: everything stays at 0.
            end
        endcase
    end

    assign ALUOp   = ALUOP_W'(alu_op);
    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Two instances: dut_a with addi/j enabled, dut_b with both disabled. Only one
// runs at a time; the other is held in reset. The stimulus process expands
// each instruction into its sequence of named steps, pushes the expected
// output vector for every cycle into a queue, and a monitor compares the
// active instance against the queue on every falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_control_fsm;

    typedef struct packed {
        logic       act;        // state_o != 0
        logic       mem_req;
        logic       IorD;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic       Branch;
        logic       PCWrite;
        logic [1:0] PCSrc;
        logic       instr_done;
        logic       illegal;
    } ov_t;

    typedef struct packed {
        ov_t        e;
        logic [7:0] step;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_a;
    logic       rst_n_b;
    logic       mem_ready;
    logic [5:0] opcode;
    logic       sel;

    always #5 clk = ~clk;

    // dut_a outputs
    logic       a_mem_req, a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg;
    logic       a_RegWrite, a_ALUSrcA, a_Branch, a_PCWrite, a_instr_done, a_illegal;
    logic [1:0] a_ALUSrcB, a_ALUOp, a_PCSrc;
    logic [3:0] a_state;
    // dut_b outputs
    logic       b_mem_req, b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg;
    logic       b_RegWrite, b_ALUSrcA, b_Branch, b_PCWrite, b_instr_done, b_illegal;
    logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSrc;
    logic [3:0] b_state;

    mc_control_fsm #(.EN_ADDI(1), .EN_JUMP(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .IorD(a_IorD), .MemWrite(a_MemWrite),
        .IRWrite(a_IRWrite), .RegDst(a_RegDst), .MemtoReg(a_MemtoReg),
        .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
        .ALUOp(a_ALUOp), .Branch(a_Branch), .PCWrite(a_PCWrite),
        .PCSrc(a_PCSrc), .instr_done(a_instr_done), .illegal(a_illegal),
        .state_o(a_state)
    );

    mc_control_fsm #(.EN_ADDI(0), .EN_JUMP(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .IorD(b_IorD), .MemWrite(b_MemWrite),
        .IRWrite(b_IRWrite), .RegDst(b_RegDst), .MemtoReg(b_MemtoReg),
        .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ALUOp(b_ALUOp), .Branch(b_Branch), .PCWrite(b_PCWrite),
        .PCSrc(b_PCSrc), .instr_done(b_instr_done), .illegal(b_illegal),
        .state_o(b_state)
    );

    ov_t va, vb;
    assign va = {(a_state != 4'd0), a_mem_req, a_IorD, a_MemWrite, a_IRWrite,
                 a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA, a_ALUSrcB,
                 a_ALUOp, a_Branch, a_PCWrite, a_PCSrc, a_instr_done, a_illegal};
    assign vb = {(b_state != 4'd0), b_mem_req, b_IorD, b_MemWrite, b_IRWrite,
                 b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_ALUSrcB,
                 b_ALUOp, b_Branch, b_PCWrite, b_PCSrc, b_instr_done, b_illegal};

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // ---------------------------------------------------------------------
    // Reference model: instruction -> sequence of steps, step -> outputs.
    //   F fetch, D decode, M address calc, R mem read, W load writeback,
    //   S mem write, X R-type execute, A R-type writeback, B beq,
    //   I addi execute, K addi writeback, J jump, Z reset/idle.
    // ---------------------------------------------------------------------
    function automatic string path(input logic [5:0] op, input bit ea, input bit ej);
        case (op)
            6'b000000: return "FDXA";
            6'b100011: return "FDMRW";
            6'b101011: return "FDMS";
            6'b000100: return "FDB";
            6'b001000: return ea ? "FDIK" : "FD";
            6'b000010: return ej ? "FDJ" : "FD";
            default:   return "FD";
        endcase
    endfunction

    function automatic ov_t expv(input logic [7:0] c, input logic rdy, input logic ill);
        ov_t v;
        v = '0;
        v.act = (c != "Z");
        case (c)
            "F": begin v.mem_req = 1; v.ALUSrcB = 2'b01; v.IRWrite = rdy; v.PCWrite = rdy; end
            "D": begin v.ALUSrcB = 2'b11; v.illegal = ill; end
            "M": begin v.ALUSrcA = 1; v.ALUSrcB = 2'b10; end
            "R": begin v.mem_req = 1; v.IorD = 1; end
            "W": begin v.RegWrite = 1; v.MemtoReg = 1; v.instr_done = 1; end
            "S": begin v.mem_req = 1; v.IorD = 1; v.MemWrite = 1; v.instr_done = rdy; end
            "X": begin v.ALUSrcA = 1; v.ALUOp = 2'b10; end
            "A": begin v.RegWrite = 1; v.RegDst = 1; v.instr_done = 1; end
            "B": begin v.ALUSrcA = 1; v.ALUOp = 2'b01; v.Branch = 1; v.PCSrc = 2'b01;
                       v.instr_done = 1; end
            "I": begin v.ALUSrcA = 1; v.ALUSrcB = 2'b10; end
            "K": begin v.RegWrite = 1; v.instr_done = 1; end
            "J": begin v.PCWrite = 1; v.PCSrc = 2'b10; v.instr_done = 1; end
            default: ;
        endcase
        return v;
    endfunction

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input logic [7:0] c, input logic rdy, input logic [5:0] opc, input logic ill);
        exp_t x;
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode    = opc;
        x.e       = expv(c, rdy, ill);
        x.step    = c;
        exp_q.push_back(x);
    endtask

    // sf/sm: wait cycles in FETCH / in the memory step (-1 = random).
    task automatic run_instr(input logic [5:0] op, input bit ea, input bit ej,
                             input int sf, input int sm);
        string      p;
        logic       ill;
        logic [7:0] c;
        int         n;
        p   = path(op, ea, ej);
        ill = (p == "FD");
        for (int i = 0; i < p.len(); i++) begin
            c = p[i];
            if (c == "F" || c == "R" || c == "S") begin
                n = (c == "F") ? sf : sm;
                if (n < 0) n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                repeat (n) cyc(c, 1'b0, 6'($urandom), ill);
                cyc(c, 1'b1, 6'($urandom), ill);
            end else if (c == "D") begin
                cyc(c, 1'($urandom), op, ill);
            end else begin
                cyc(c, 1'($urandom), 6'($urandom), ill);
            end
        end
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b001000;
            5: return 6'b000010;
            default: return 6'($urandom);
        endcase
    endfunction

    // sw stalled in MEM_WR, reset dropped between clock edges.
    task automatic sw_abort();
        exp_t x;
        cyc("F", 1'b1, 6'($urandom), 1'b0);
        cyc("D", 1'b0, 6'b101011, 1'b0);
        cyc("M", 1'($urandom), 6'($urandom), 1'b0);
        cyc("S", 1'b0, 6'($urandom), 1'b0);
        cyc("S", 1'b0, 6'($urandom), 1'b0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        x.e    = expv("Z", 1'b0, 1'b0);
        x.step = "Z";
        exp_q.push_back(x);
        #1;
        check("sw_stall_memwrite", {30'd0, a_MemWrite, a_mem_req}, 32'h3);
        rst_n_a = 1'b0;
        #1;
        check("async_rst_drop", {30'd0, a_MemWrite, a_mem_req}, 32'h0);
        cyc("Z", 1'b0, 6'($urandom), 1'b0);
        cyc("Z", 1'b0, 6'($urandom), 1'b0);
        rst_n_a = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    initial begin
        exp_t e;
        ov_t  act;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = sel ? vb : va;
                check($sformatf("dut_%s cycle %0d step %s", sel ? "b" : "a", cyc_n, e.step),
                      32'(act), 32'(e.e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        sel       = 1'b0;
        rst_n_a   = 1'b0;
        rst_n_b   = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;

        // Phase A: dut_a (addi and j enabled)
        repeat (3) cyc("Z", 1'($urandom), 6'($urandom), 1'b0);
        cyc("Z", 1'b0, 6'($urandom), 1'b0);
        rst_n_a = 1'b1;                           // IDLE this cycle, FETCH next

        run_instr(6'b000000, 1, 1, 0, 0);         // R-type, 4 cycles
        run_instr(6'b100011, 1, 1, 2, 1);         // lw, 8 cycles
        run_instr(6'b000100, 1, 1, 0, 0);         // beq, 3 cycles
        run_instr(6'b101011, 1, 1, 0, 3);         // sw, 3-cycle stall
        run_instr(6'b000010, 1, 1, 0, 0);         // j
        run_instr(6'b001000, 1, 1, 0, 0);         // addi
        run_instr(6'b111111, 1, 1, 0, 0);         // illegal
        for (int i = 0; i < 150; i++) run_instr(rand_op(), 1, 1, -1, -1);
        sw_abort();
        for (int i = 0; i < 20; i++) run_instr(rand_op(), 1, 1, -1, -1);

        // Phase B: dut_b (addi and j disabled)
        cyc("Z", 1'b0, 6'($urandom), 1'b0);
        rst_n_a = 1'b0;
        sel     = 1'b1;
        cyc("Z", 1'b0, 6'($urandom), 1'b0);
        rst_n_b = 1'b1;
        run_instr(6'b000010, 0, 0, 0, 0);         // j -> illegal
        run_instr(6'b001000, 0, 0, 0, 0);         // addi -> illegal
        for (int i = 0; i < 60; i++) run_instr(rand_op(), 0, 0, -1, -1);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
